// File: rtl/led_pwm_fader.sv
// Per-channel LED PWM fader: ramps each channel's duty between off and full on.
// Define LED_PWM_ACTIVE_LOW_EN to drive active-low LED boards (led_out inverted).
module led_pwm_fader #(
  parameter int NUM_LED  = 4,
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_LED-1:0] led_in,
  input  logic               enable,
  output logic [NUM_LED-1:0] led_out,
  output logic [NUM_LED-1:0] fading
);

  localparam int STEP_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MIN = '0;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                step_tick;

  state_t              state_q [NUM_LED];
  state_t              state_d [NUM_LED];
  logic [PWM_BITS-1:0] duty_q  [NUM_LED];
  logic [PWM_BITS-1:0] duty_d  [NUM_LED];

  logic [NUM_LED-1:0]  drive_d;
  logic [NUM_LED-1:0]  fading_d;

  assign step_tick = enable && (step_cnt == STEP_W'(FADE_DIV - 1));

  // PWM counter free-runs; the fade prescaler only advances while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (enable) begin
        if (step_tick)
          step_cnt <= '0;
        else
          step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LED; i++) begin
        state_q[i] <= OFF;
        duty_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  // A led_in reversal takes priority over a step in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      if (enable) begin
        case (state_q[i])
          OFF: begin
            if (led_in[i]) state_d[i] = RISE;
          end
          RISE: begin
            if (!led_in[i]) begin
              state_d[i] = FALL;
            end else if (step_tick) begin
              if (duty_q[i] != DUTY_MAX) duty_d[i] = duty_q[i] + PWM_BITS'(1);
              if (duty_d[i] == DUTY_MAX) state_d[i] = ON;
            end
          end
          ON: begin
            if (!led_in[i]) state_d[i] = FALL;
          end
          FALL: begin
            if (led_in[i]) begin
              state_d[i] = RISE;
            end else if (step_tick) begin
              if (duty_q[i] != DUTY_MIN) duty_d[i] = duty_q[i] - PWM_BITS'(1);
              if (duty_d[i] == DUTY_MIN) state_d[i] = OFF;
            end
          end
          default: state_d[i] = OFF;
        endcase
      end
    end
  end

  always_comb begin
    drive_d  = '0;
    fading_d = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      drive_d[i]  = enable && ((duty_q[i] == DUTY_MAX) || (pwm_cnt < duty_q[i]));
      fading_d[i] = (state_q[i] == RISE) || (state_q[i] == FALL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LED_PWM_ACTIVE_LOW_EN
      led_out <= '1;
`else
      led_out <= '0;
`endif
      fading  <= '0;
    end else begin
`ifdef LED_PWM_ACTIVE_LOW_EN
      led_out <= ~drive_d;
`else
      led_out <= drive_d;
`endif
      fading  <= fading_d;
    end
  end

endmodule
